// File: rtl/sram_wr_sched_if.sv
// Requester beat stream into the SRAM write scheduler.
// A beat moves when valid and ready are both high on a rising clock edge.
interface sram_wr_sched_if #(
    parameter int BUS_SIZE  = 32,
    parameter int DAT_SIZE  = 8,
    parameter int DAT_CNT_W = 2
);
    logic                         valid;
    logic                         ready;
    logic                         last;
    logic [BUS_SIZE-1:0]          smap;
    logic [BUS_SIZE*DAT_SIZE-1:0] data;
    logic [DAT_CNT_W-1:0]         dcnt;

    modport master (output valid, last, smap, data, dcnt, input ready);
    modport slave  (input valid, last, smap, data, dcnt, output ready);
endinterface

// File: rtl/sram_wr_sched.sv
// Shares one SRAM write port between the filter and IFM chunk streams.
// Arbitration is per chunk, and done_o pulses once both programmed chunk totals are written.
module sram_wr_sched #(
    parameter int BUS_SIZE  = 32,
    parameter int DAT_SIZE  = 8,
    parameter int DAT_CNT_W = 2,
    parameter int CHUNK_W   = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [CHUNK_W-1:0]           fil_total_i,
    input  logic [CHUNK_W-1:0]           ifm_total_i,
    sram_wr_sched_if.slave               fil_if,
    sram_wr_sched_if.slave               ifm_if,
    output logic                         wr_valid_o,
    input  logic                         wr_ready_i,
    output logic                         wr_sel_o,
    output logic [BUS_SIZE-1:0]          wr_smap_o,
    output logic [BUS_SIZE*DAT_SIZE-1:0] wr_data_o,
    output logic [DAT_CNT_W-1:0]         wr_dcnt_o,
    output logic [CHUNK_W-1:0]           wr_chunk_o,
    output logic                         done_o,
    output logic                         err_o
);
    typedef enum logic [2:0] {IDLE, ARB, GNT_FIL, GNT_IFM, DRAIN} state_e;

    state_e                       state_q;
    logic [CHUNK_W-1:0]           fil_total_q, ifm_total_q;
    logic [CHUNK_W-1:0]           fil_cnt_q, ifm_cnt_q;
    logic [CHUNK_W-1:0]           fil_cnt_d, ifm_cnt_d;
    logic                         rr_fil_q;
    logic                         wr_valid_q, wr_sel_q, done_q, err_q;
    logic [BUS_SIZE-1:0]          wr_smap_q;
    logic [BUS_SIZE*DAT_SIZE-1:0] wr_data_q;
    logic [DAT_CNT_W-1:0]         wr_dcnt_q;
    logic [CHUNK_W-1:0]           wr_chunk_q;

    logic fil_done, ifm_done, fil_elig, ifm_elig;
    logic out_free, fil_acc, ifm_acc, arb_or_gnt;

    assign fil_done   = (fil_cnt_q == fil_total_q);
    assign ifm_done   = (ifm_cnt_q == ifm_total_q);
    assign fil_elig   = fil_if.valid && !fil_done;
    assign ifm_elig   = ifm_if.valid && !ifm_done;
    assign fil_cnt_d  = fil_cnt_q + 1'b1;
    assign ifm_cnt_d  = ifm_cnt_q + 1'b1;
    assign arb_or_gnt = (state_q == ARB) || (state_q == GNT_FIL) || (state_q == GNT_IFM);

    // The single output register may take a new beat when empty or being drained this cycle.
    assign out_free     = !wr_valid_q || wr_ready_i;
    assign fil_if.ready = (state_q == GNT_FIL) && out_free && !fil_done;
    assign ifm_if.ready = (state_q == GNT_IFM) && out_free && !ifm_done;
    assign fil_acc      = fil_if.valid && fil_if.ready;
    assign ifm_acc      = ifm_if.valid && ifm_if.ready;

    // NOTE: the data-path registers are reset as well so that every output reads 0 after reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            fil_total_q <= '0;
            ifm_total_q <= '0;
            fil_cnt_q   <= '0;
            ifm_cnt_q   <= '0;
            rr_fil_q    <= 1'b1;
            wr_valid_q  <= 1'b0;
            wr_sel_q    <= 1'b0;
            wr_smap_q   <= '0;
            wr_data_q   <= '0;
            wr_dcnt_q   <= '0;
            wr_chunk_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // NOTE: later non-blocking assignments in this block override these defaults.
            if (wr_valid_q && wr_ready_i) wr_valid_q <= 1'b0;
            if (arb_or_gnt && ((fil_if.valid && fil_done) || (ifm_if.valid && ifm_done)))
                err_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        fil_total_q <= fil_total_i;
                        ifm_total_q <= ifm_total_i;
                        fil_cnt_q   <= '0;
                        ifm_cnt_q   <= '0;
                        err_q       <= 1'b0;
                        state_q     <= ARB;
                    end
                end
                ARB: begin
                    if (fil_done && ifm_done) begin
                        state_q <= DRAIN;
                    end else if (fil_elig && ifm_elig) begin
                        state_q  <= rr_fil_q ? GNT_FIL : GNT_IFM;
                        rr_fil_q <= !rr_fil_q;
                    end else if (fil_elig) begin
                        state_q <= GNT_FIL;
                    end else if (ifm_elig) begin
                        state_q <= GNT_IFM;
                    end
                end
                GNT_FIL: begin
                    if (fil_acc) begin
                        wr_valid_q <= 1'b1;
                        wr_sel_q   <= 1'b1;
                        wr_smap_q  <= fil_if.smap;
                        wr_data_q  <= fil_if.data;
                        wr_dcnt_q  <= fil_if.dcnt;
                        wr_chunk_q <= fil_cnt_q;
                        if (fil_if.last) begin
                            fil_cnt_q <= fil_cnt_d;
                            state_q   <= ARB;
                        end
                    end
                end
                GNT_IFM: begin
                    if (ifm_acc) begin
                        wr_valid_q <= 1'b1;
                        wr_sel_q   <= 1'b0;
                        wr_smap_q  <= ifm_if.smap;
                        wr_data_q  <= ifm_if.data;
                        wr_dcnt_q  <= ifm_if.dcnt;
                        wr_chunk_q <= ifm_cnt_q;
                        if (ifm_if.last) begin
                            ifm_cnt_q <= ifm_cnt_d;
                            state_q   <= ARB;
                        end
                    end
                end
                DRAIN: begin
                    if (!wr_valid_q) begin
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_valid_o = wr_valid_q;
    assign wr_sel_o   = wr_sel_q;
    assign wr_smap_o  = wr_smap_q;
    assign wr_data_o  = wr_data_q;
    assign wr_dcnt_o  = wr_dcnt_q;
    assign wr_chunk_o = wr_chunk_q;
    assign done_o     = done_q;
    assign err_o      = err_q;
endmodule
